sdram_data_path: RTL and testbench

//  Parametrised SDRAM DQ datapath, successor to the fixed-width data block; driven by explicit burst strobes, not work_state.

---
 rtl/sdram_data_path_pkg.sv | 17 +
 rtl/sdram_rd_align.sv | 45 ++++
 rtl/sdram_data_path.sv | 131 +++++++++++++
 tb/tb_sdram_data_path.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_data_path_pkg.sv
// Shared defaults and FSM state codes for the SDRAM DQ datapath.
// Optional DQM byte masking is enabled by defining SDRAM_DQM_EN.
package sdram_data_path_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CAS_LAT = 3;
  localparam int DEF_LEN_W   = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  function automatic int byte_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sdram_rd_align.sv
// Read capture alignment: a CAS_LAT+1 deep beat-issue shift register whose
// output strobes DQ into the capture register one cycle later as rd_valid.
module sdram_rd_align
  import sdram_data_path_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CAS_LAT = DEF_CAS_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [DATA_W-1:0] dq_in,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              dq_busy
);

  logic [CAS_LAT:0]  vld_q, vld_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    vld_d      = {vld_q[CAS_LAT-1:0], issue};
    rd_valid_d = vld_q[CAS_LAT];
    // Only load the capture register on real beats so rd_data holds otherwise.
    rd_data_d  = vld_q[CAS_LAT] ? dq_in : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign dq_busy  = |vld_q;

endmodule

// File: rtl/sdram_data_path.sv
// SDRAM DQ datapath: strobe-driven write beat registration onto tri-state DQ,
// CAS-aligned read capture and burst counting. Define SDRAM_DQM_EN for wr_be/DQM.
module sdram_data_path
  import sdram_data_path_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CAS_LAT = DEF_CAS_LAT,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_start,
  input  logic                rd_start,
  input  logic [LEN_W-1:0]    burst_len,
  input  logic                burst_stop,
  input  logic [DATA_W-1:0]   wr_data,
`ifdef SDRAM_DQM_EN
  input  logic [DATA_W/8-1:0] wr_be,
`endif
  output logic                wr_data_req,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                dq_busy,
  output logic                err,
  output logic [DATA_W/8-1:0] sdram_dqm,
  inout  wire  [DATA_W-1:0]   sdram_data
);

  localparam int BYTE_W = byte_w(DATA_W);
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              oe_q, oe_d;
  logic [BYTE_W-1:0] dqm_q, dqm_d;
  logic              err_q, err_d;
  logic              wr_acc, rd_acc, wr_beat, rd_beat, len_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    wr_beat = 1'b0;
    rd_beat = 1'b0;
    len_ok  = (burst_len != '0);
    case (state_q)
      ST_IDLE: begin
        // A simultaneous read request always loses; the write still needs a clear bus.
        wr_acc  = wr_start && len_ok && !dq_busy;
        rd_acc  = rd_start && !wr_start && len_ok;
        wr_beat = wr_acc;
        rd_beat = rd_acc;
        if (wr_acc || rd_acc) begin
          // cnt holds beats still to issue after the start-cycle beat.
          cnt_d = burst_len - 1'b1;
          if (burst_len != CNT_ONE) begin
            state_d = wr_acc ? ST_WR : ST_RD;
          end
        end
      end
      ST_WR, ST_RD: begin
        if (burst_stop) begin
          state_d = ST_IDLE;
        end else begin
          wr_beat = (state_q == ST_WR);
          rd_beat = (state_q == ST_RD);
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dq_out_d = wr_beat ? wr_data : dq_out_q;
    oe_d     = wr_beat;
`ifdef SDRAM_DQM_EN
    dqm_d    = wr_beat ? ~wr_be : '0;
`else
    dqm_d    = '0;
`endif
    err_d    = err_q
             | (wr_start && rd_start)
             | ((wr_start || rd_start) && (state_q != ST_IDLE))
             | (wr_start && dq_busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      dqm_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      dqm_q    <= dqm_d;
      err_q    <= err_d;
    end
  end

  sdram_rd_align #(
    .DATA_W  (DATA_W),
    .CAS_LAT (CAS_LAT)
  ) u_rd_align (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (rd_beat),
    .dq_in    (sdram_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .dq_busy  (dq_busy)
  );

  assign sdram_data  = oe_q ? dq_out_q : {DATA_W{1'bz}};
  assign wr_data_req = wr_beat;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign sdram_dqm   = dqm_q;

endmodule

// File: tb/tb_sdram_data_path.sv
// Self-checking bench for sdram_data_path; per-cycle expectations are derived
// from burst rules (start offset, length, stop offset, CAS latency).
module tb_sdram_data_path;

  localparam int DW = 16;
  localparam int CL = 3;
  localparam int LW = 10;
  localparam int BW = DW / 8;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_start = 1'b0, rd_start = 1'b0, burst_stop = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic [BW-1:0] wr_be = '1;
  logic          wr_data_req, rd_valid, busy, dq_busy, err;
  logic [DW-1:0] rd_data;
  logic [BW-1:0] sdram_dqm;
  wire  [DW-1:0] dq;
  logic          tb_oe = 1'b0;
  logic [DW-1:0] tb_dq = '0;

  assign dq = tb_oe ? tb_dq : {DW{1'bz}};

  always #5 clk = ~clk;

  sdram_data_path #(.DATA_W(DW), .CAS_LAT(CL), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_start    (wr_start),
    .rd_start    (rd_start),
    .burst_len   (burst_len),
    .burst_stop  (burst_stop),
    .wr_data     (wr_data),
`ifdef SDRAM_DQM_EN
    .wr_be       (wr_be),
`endif
    .wr_data_req (wr_data_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .dq_busy     (dq_busy),
    .err         (err),
    .sdram_dqm   (sdram_dqm),
    .sdram_data  (dq)
  );

  int checks = 0;
  int errors = 0;

  logic          in_ws[N], in_rs[N], in_stop[N], drv[N];
  logic [LW-1:0] in_len[N];
  logic [DW-1:0] in_wd[N], drv_val[N], ex_dq[N], ex_rd[N];
  logic [BW-1:0] in_be[N], ex_dqm[N];
  logic          ex_req[N], ex_busy[N], ex_dqb[N], ex_oe[N], ex_valid[N];
  int            err_from;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnz();
    logic [DW-1:0] v;
    v = DW'($urandom);
    if (v == '0) v = 1;
    return v;
  endfunction

  function automatic logic dq_free();
    return (dq === {DW{1'bz}}) || (dq === {DW{1'b0}});
  endfunction

  task automatic clear_scn();
    for (int i = 0; i < N; i++) begin
      in_ws[i] = 0; in_rs[i] = 0; in_stop[i] = 0; drv[i] = 0;
      in_len[i] = LW'($urandom); in_wd[i] = DW'($urandom); in_be[i] = BW'($urandom);
      drv_val[i] = '0; ex_dq[i] = '0; ex_rd[i] = '0; ex_dqm[i] = '0;
      ex_req[i] = 0; ex_busy[i] = 0; ex_dqb[i] = 0; ex_oe[i] = 0; ex_valid[i] = 0;
    end
    err_from = N + 1;
  endtask

  // Accepted burst starting at offset s; stop_off (relative, 0 = none) ends issue early.
  task automatic add_write(input int s, input int len, input int stop_off, input int base);
    int nb, lb;
    bit stopped;
    stopped = (stop_off > 0) && (stop_off < len);
    nb = stopped ? stop_off : len;
    lb = stopped ? stop_off : len - 1;
    in_ws[s] = 1; in_len[s] = LW'(len);
    if (stop_off > 0) in_stop[s + stop_off] = 1;
    for (int i = 0; i < nb; i++) begin
      in_wd[s + i] = (base != 0) ? DW'(base + i) : rnz();
      ex_req[s + i] = 1;
      ex_oe[s + 1 + i] = 1;
      ex_dq[s + 1 + i] = in_wd[s + i];
`ifdef SDRAM_DQM_EN
      ex_dqm[s + 1 + i] = ~in_be[s + i];
`else
      ex_dqm[s + 1 + i] = '0;
`endif
    end
    for (int t = 1; t <= lb; t++) ex_busy[s + t] = 1;
  endtask

  task automatic add_read(input int s, input int len, input int stop_off, input int base);
    int nb, lb;
    bit stopped;
    stopped = (stop_off > 0) && (stop_off < len);
    nb = stopped ? stop_off : len;
    lb = stopped ? stop_off : len - 1;
    in_rs[s] = 1; in_len[s] = LW'(len);
    if (stop_off > 0) in_stop[s + stop_off] = 1;
    for (int i = 0; i < nb; i++) begin
      drv[s + CL + 1 + i] = 1;
      drv_val[s + CL + 1 + i] = (base != 0) ? DW'(base + i) : rnz();
      ex_valid[s + CL + 2 + i] = 1;
      ex_rd[s + CL + 2 + i] = drv_val[s + CL + 1 + i];
    end
    for (int t = 1; t <= lb; t++) ex_busy[s + t] = 1;
    for (int t = s + 1; t <= s + nb + CL; t++) ex_dqb[t] = 1;
  endtask

  task automatic idle_inputs();
    wr_start = 0; rd_start = 0; burst_stop = 0; burst_len = '0; tb_oe = 0;
  endtask

  task automatic run_scn(input int n, input string name);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      chk({name, ".busy"}, busy, ex_busy[t]);
      chk({name, ".dq_busy"}, dq_busy, ex_dqb[t]);
      chk({name, ".err"}, err, (t >= err_from) ? 1 : 0);
      chk({name, ".rd_valid"}, rd_valid, ex_valid[t]);
      if (ex_valid[t]) chk({name, ".rd_data"}, rd_data, ex_rd[t]);
      chk({name, ".dqm"}, sdram_dqm, ex_dqm[t]);
      if (ex_oe[t]) chk({name, ".dq"}, dq, ex_dq[t]);
      else if (!tb_oe) chk({name, ".dq_z"}, dq_free(), 1);
      wr_start = in_ws[t]; rd_start = in_rs[t]; burst_stop = in_stop[t];
      burst_len = in_len[t]; wr_data = in_wd[t]; wr_be = in_be[t];
      tb_oe = drv[t]; tb_dq = drv_val[t];
      #1;
      chk({name, ".wr_data_req"}, wr_data_req, ex_req[t]);
    end
    idle_inputs();
    $display("scenario %s: %0d cycles", name, n);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    int len, stp;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.dq_busy", dq_busy, 0);
    chk("rst.err", err, 0);
    chk("rst.rd_valid", rd_valid, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.dqm", sdram_dqm, 0);
    chk("rst.dq_z", dq_free(), 1);
    @(posedge clk); #2 rst_n = 1;

    clear_scn(); add_write(2, 4, 0, 1); run_scn(10, "wr4");
    clear_scn(); add_read(1, 8, 0, 'hA0); run_scn(16, "rd8");
    clear_scn(); add_write(1, 8, 2, 0); run_scn(14, "wr8_stop");

    for (int k = 0; k < 10; k++) begin
      clear_scn();
      len = $urandom_range(1, 12);
      stp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
      in_stop[0] = 1'($urandom);
      if ($urandom_range(0, 1) == 1) add_write(1, len, stp, 0);
      else add_read(1, len, stp, 0);
      run_scn(len + CL + 6, "random");
    end

    clear_scn(); add_read(0, 3, 0, 'h10); add_read(3, 3, 0, 'h20); run_scn(14, "rd_b2b");
    clear_scn(); add_write(0, 1, 0, 0); add_read(2, 1, 0, 0); run_scn(10, "len1");
    clear_scn(); in_be[0] = 2'b01; add_write(0, 1, 0, 0); run_scn(5, "dqm");

    clear_scn();
    in_ws[1] = 1; in_len[1] = 0; in_rs[3] = 1; in_len[3] = 0; in_stop[5] = 1;
    run_scn(8, "len0");

    clear_scn(); add_write(1, 4, 0, 0); in_rs[1] = 1; err_from = 2; run_scn(9, "wr_rd_same");
    do_reset();
    clear_scn(); add_read(0, 1, 0, 'hB0); in_ws[1] = 1; in_len[1] = 2; err_from = 2;
    run_scn(10, "wr_dq_busy");
    do_reset();
    clear_scn(); add_write(0, 5, 0, 0); in_rs[2] = 1; in_len[2] = 3; err_from = 3;
    run_scn(9, "start_busy");
    do_reset();

    clear_scn(); add_write(0, 8, 0, 0); run_scn(4, "wr_pre_rst");
    #1 rst_n = 0;
    #1;
    chk("rst_wr.dq_z", dq_free(), 1);
    chk("rst_wr.busy", busy, 0);
    chk("rst_wr.dqm", sdram_dqm, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    clear_scn(); run_scn(6, "wr_post_rst");

    clear_scn(); add_read(0, 8, 0, 'hC0); run_scn(7, "rd_pre_rst");
    #1 tb_oe = 0; rst_n = 0;
    #1;
    chk("rst_rd.rd_valid", rd_valid, 0);
    chk("rst_rd.dq_busy", dq_busy, 0);
    chk("rst_rd.busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    clear_scn(); run_scn(16, "rd_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
